// File: rtl/serial_subtractor_pkg.sv
// Shared constants and state encoding for the bit-serial arithmetic units.
// The ripple adder uses the same default operand width.
package serial_subtractor_pkg;

    localparam int ARITH_W = 4;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_SHIFT = 2'd1,
        SS_DONE  = 2'd2
    } ss_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor; the master issues operations.
interface serial_subtractor_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic [N-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;

    modport master (
        output start, A, B, Bin,
        input  D, Bout, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, busy, done
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first: {Bout, D} = A - B - Bin.
// Operands are captured on start; the result appears with a one-cycle done pulse.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = ARITH_W
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    ss_state_t      state;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    logic [N-1:0]   rd;
    logic           br;
    logic [CW-1:0]  count;

    logic [N-1:0]   d_out;
    logic           bout_out;
    logic           busy_out;
    logic           done_out;

    logic           d_bit;
    logic           b_next;

    full_subtractor u_bit_slice (
        .a    (ra[0]),
        .b    (rb[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (b_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SS_IDLE;
            ra       <= '0;
            rb       <= '0;
            rd       <= '0;
            br       <= 1'b0;
            count    <= '0;
            d_out    <= '0;
            bout_out <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                SS_IDLE: begin
                    if (bus.start) begin
                        ra       <= bus.A;
                        rb       <= bus.B;
                        br       <= bus.Bin;
                        rd       <= '0;
                        count    <= '0;
                        busy_out <= 1'b1;
                        state    <= SS_SHIFT;
                    end
                end
                SS_SHIFT: begin
                    // Result bits enter at the top so after N shifts rd holds D in place.
                    rd    <= {d_bit, rd[N-1:1]};
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    br    <= b_next;
                    count <= count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        state <= SS_DONE;
                    end
                end
                SS_DONE: begin
                    // D and Bout change together, so no partial result is ever visible.
                    d_out    <= rd;
                    bout_out <= br;
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= SS_IDLE;
                end
                default: begin
                    state    <= SS_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

    assign bus.D    = d_out;
    assign bus.Bout = bout_out;
    assign bus.busy = busy_out;
    assign bus.done = done_out;

endmodule
